hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised operand-hazard controller for the pipelined MIPS core, sitting beside the ID/EX pipeline register. It tracks every in-flight register writer from EX through WB in its own shift pipeline and does three jobs:
- Generates registered per-operand forwarding selects for the EX stage.
- Generates ID-stage write-through bypass flags.
- Raises a load-use / partial-write stall; a saturating stall counter records the stalled cycles.

It generalises the fixed Rs/Rt forwarding logic to NUM_SRC operands, a configurable writer depth, load latency and byte-lane writes.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- BYTES, 4, byte lanes per register (width of a write byte-enable).
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 2, writer stages tracked past EX (1 = EX/MEM, 2 = MEM/WB, …); minimum 2.
- LOAD_STAGE, 2, first writer stage (1..DEPTH) at which load data is forwardable.
- SW = clog2(DEPTH+1), derived, width of one forwarding select.

Ports:
- clk  in  1  core clock; everything samples on the rising edge.
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset (decided).
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source register numbers; operand i in slice i.
- id_src_valid  in  NUM_SRC  per-operand "reads a register".
- id_dst  in  REG_AW  destination register.
- id_be  in  BYTES  destination byte-enables; all zero means no write.
- id_is_load  in  1  the destination is written from memory.
- pipe_hold  in  1  global freeze, for example while memory is busy.
- flush  in  1  squash the instruction in ID and the instruction in EX.
- stall  out  1  combinational; ID must not advance.
- id_bypass  out  NUM_SRC  combinational; the register-file read for this operand must use the WB write data.
- ex_fwd_sel  out  NUM_SRC*SW  registered; EX operand source. 0 = register file, k = writer stage k.
- stall_count  out  32  saturating count of cycles with stall high and pipe_hold low.

## Operation
Writer pipeline:
- Entries e0 (EX) and e1..eDEPTH. Each entry holds valid, dst, be and is_load.
- An entry is a writer only when valid is 1, be is non-zero and dst is non-zero. Register 0 never matches.
- Advance condition: pipe_hold is 0.
  - e[k+1] takes e[k] for k = 0..DEPTH-1. The old eDEPTH drops out.
  - e0 takes the ID instruction when id_valid=1, stall=0 and flush=0. Otherwise e0 takes a bubble (valid=0).
  - When flush=1, the bubble also overwrites the entry shifting out of e0: that entry becomes invalid in e1.

Match rules, evaluated per operand i with id_src_valid[i]=1:
- Consider entries e0..eDEPTH whose dst equals id_src[i].
- The youngest match wins, meaning the lowest index.

Outputs from the winning match at position k:
- k < DEPTH: the next ex_fwd_sel[i] is k+1. This is the entry's stage position when the consumer reaches EX.
- k = DEPTH: id_bypass[i] = 1 and the next ex_fwd_sel[i] is 0.
- No match: id_bypass[i] = 0 and the next ex_fwd_sel[i] is 0.

The stall condition is any operand whose winning match:
- is a load with k+1 < LOAD_STAGE, or
- has be ≠ all-ones while k < DEPTH. A partial write is never forwarded; the consumer waits until that writer is in eDEPTH, where write-through merges in the register file.

Stall and flush interaction:
- stall is forced to 0 when id_valid=0 or flush=1.
- A stalled cycle loads the next ex_fwd_sel with 0, because the stall inserts a bubble into EX.

Hold:
- When pipe_hold=1, the entries, ex_fwd_sel and stall_count all hold their values.
- flush is ignored during hold; the controller keeps flush asserted until the hold drops.
- stall and id_bypass keep tracking their inputs combinationally.

stall_count increments when stall=1 and pipe_hold=0, and saturates at 0xFFFF_FFFF.

## Timing
- Reset: all entries invalid, ex_fwd_sel=0 and stall_count=0. With entries empty, stall and id_bypass are 0 in the cycle after reset.
- Decision latency: ex_fwd_sel appears 1 cycle after the consumer is seen in ID, the same edge on which the consumer enters EX.
- stall and id_bypass are valid in the same cycle as their inputs, with no registers.
- Load-use with default parameters:
  - A consumer immediately behind a load stalls exactly 1 cycle.
  - It then forwards from stage 2 (MEM/WB).
- A dependence at distance 3 (default DEPTH) gives id_bypass only, with no stall.
- reset asserted mid-stall clears everything on that edge. stall drops in the following cycle unless the inputs recreate it, which they cannot with all entries invalid.

## Test plan
- ALU chain: add r3 then sub r4,r3,r3 back-to-back. Required: no stall, and ex_fwd_sel = {1,1} in sub's EX cycle. With 1 instruction between: {2,2}. With 2 between: id_bypass=2'b11 in ID and ex_fwd_sel=0.
- Load-use: lw r5 then add r6,r5,r0. Required: stall=1 for exactly 1 cycle, a bubble enters EX (ex_fwd_sel=0), then ex_fwd_sel[0]=2 with the consumer in EX, and stall_count reads 1.
- Priority and r0: two writers to r7 at e0 and e1, then a consumer of r7. Required: select 1 from the younger writer. A writer to r0 followed by a consumer of r0 never forwards or stalls.
- Partial write: sb-style writer of r8 with be=4'b0001, then a consumer. Required: stall while the writer is at e0..e(DEPTH-1), release with id_bypass=1, and stall_count increments by DEPTH.
- Flush and hold: flush during a load-use stall. Required: stall=0 and e0 and e1 invalid, with no forward afterwards. pipe_hold=1 for 3 cycles mid-sequence. Required: ex_fwd_sel and stall_count frozen, and forwarding correct after release.
- Parametrised build with NUM_SRC=3, DEPTH=4, LOAD_STAGE=3. Required: a load followed by a consumer stalls 2 cycles then selects 3, and a distance-5 dependence gives id_bypass.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Operand-hazard controller beside the ID/EX register: tracks in-flight writers EX..eDEPTH and
// produces EX forwarding selects, ID write-through bypass flags and a load-use/partial-write stall.
module hazard_forward_unit #(
  parameter int REG_AW     = 5,
  parameter int BYTES      = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic [BYTES-1:0]          id_be,
  input  logic                      id_is_load,
  input  logic                      pipe_hold,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC-1:0]        id_bypass,
  output logic [NUM_SRC*SW-1:0]     ex_fwd_sel,
  output logic [31:0]               stall_count
);

  // Writer pipeline: index 0 is EX, index DEPTH is the write-back end.
  logic              ent_valid_r [0:DEPTH];
  logic [REG_AW-1:0] ent_dst_r   [0:DEPTH];
  logic [BYTES-1:0]  ent_be_r    [0:DEPTH];
  logic              ent_load_r  [0:DEPTH];

  logic              win_hit_s  [NUM_SRC];
  logic [SW-1:0]     win_pos_s  [NUM_SRC];
  logic [BYTES-1:0]  win_be_s   [NUM_SRC];
  logic              win_load_s [NUM_SRC];

  logic [NUM_SRC-1:0]    bypass_s;
  logic [NUM_SRC-1:0]    op_stall_s;
  logic [NUM_SRC*SW-1:0] fwd_s;
  logic                  stall_s;
  logic                  advance_s;
  logic [NUM_SRC*SW-1:0] ex_fwd_sel_r;
  logic [31:0]           stall_count_r;

  function automatic logic writer_hit(
    input logic              v,
    input logic [BYTES-1:0]  be,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] src
  );
    return v && (be != {BYTES{1'b0}}) && (dst != {REG_AW{1'b0}}) && (dst == src);
  endfunction

  // Youngest matching writer per operand: scanning oldest to youngest lets the lowest index win.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      win_hit_s[i]  = 1'b0;
      win_pos_s[i]  = {SW{1'b0}};
      win_be_s[i]   = {BYTES{1'b0}};
      win_load_s[i] = 1'b0;
      for (int k = DEPTH; k >= 0; k--) begin
        win_pos_s[i]  = writer_hit(ent_valid_r[k], ent_be_r[k], ent_dst_r[k],
                                   id_src[i*REG_AW +: REG_AW]) ? SW'(k) : win_pos_s[i];
        win_be_s[i]   = writer_hit(ent_valid_r[k], ent_be_r[k], ent_dst_r[k],
                                   id_src[i*REG_AW +: REG_AW]) ? ent_be_r[k] : win_be_s[i];
        win_load_s[i] = writer_hit(ent_valid_r[k], ent_be_r[k], ent_dst_r[k],
                                   id_src[i*REG_AW +: REG_AW]) ? ent_load_r[k] : win_load_s[i];
        win_hit_s[i]  = win_hit_s[i] | writer_hit(ent_valid_r[k], ent_be_r[k], ent_dst_r[k],
                                                  id_src[i*REG_AW +: REG_AW]);
      end
    end
  end

  // Per-operand decisions; a partial write is never forwarded, only merged at the tail stage.
  always_comb begin
    bypass_s   = {NUM_SRC{1'b0}};
    op_stall_s = {NUM_SRC{1'b0}};
    fwd_s      = {NUM_SRC*SW{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      bypass_s[i]   = id_src_valid[i] && win_hit_s[i] && (win_pos_s[i] == SW'(DEPTH));
      op_stall_s[i] = id_src_valid[i] && win_hit_s[i] &&
                      ((win_load_s[i] && (int'(win_pos_s[i]) < (LOAD_STAGE - 32'sd1))) ||
                       ((win_be_s[i] != {BYTES{1'b1}}) && (win_pos_s[i] != SW'(DEPTH))));
      fwd_s[i*SW +: SW] = (id_src_valid[i] && win_hit_s[i] && (win_pos_s[i] != SW'(DEPTH)))
                          ? (win_pos_s[i] + SW'(1)) : {SW{1'b0}};
    end
  end

  // Global stall and the condition under which the ID instruction enters EX.
  always_comb begin
    stall_s   = 1'b0;
    advance_s = 1'b0;
    if (id_valid && !flush) begin
      stall_s   = |op_stall_s;
      advance_s = ~(|op_stall_s);
    end else begin
      stall_s   = 1'b0;
      advance_s = 1'b0;
    end
  end

  assign stall       = stall_s;
  assign id_bypass   = bypass_s;
  assign ex_fwd_sel  = ex_fwd_sel_r;
  assign stall_count = stall_count_r;

  // Writer shift pipeline; flush also kills the entry leaving EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DEPTH; k++) begin
        ent_valid_r[k] <= 1'b0;
        ent_dst_r[k]   <= {REG_AW{1'b0}};
        ent_be_r[k]    <= {BYTES{1'b0}};
        ent_load_r[k]  <= 1'b0;
      end
    end else if (!pipe_hold) begin
      for (int k = 2; k <= DEPTH; k++) begin
        ent_valid_r[k] <= ent_valid_r[k-1];
        ent_dst_r[k]   <= ent_dst_r[k-1];
        ent_be_r[k]    <= ent_be_r[k-1];
        ent_load_r[k]  <= ent_load_r[k-1];
      end
      ent_valid_r[1] <= ent_valid_r[0] && !flush;
      ent_dst_r[1]   <= ent_dst_r[0];
      ent_be_r[1]    <= ent_be_r[0];
      ent_load_r[1]  <= ent_load_r[0];
      ent_valid_r[0] <= advance_s;
      ent_dst_r[0]   <= id_dst;
      ent_be_r[0]    <= id_be;
      ent_load_r[0]  <= id_is_load;
    end
  end

  // EX forwarding selects; a stalled, flushed or empty slot sends a bubble with select 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_fwd_sel_r <= {NUM_SRC*SW{1'b0}};
    end else if (!pipe_hold) begin
      ex_fwd_sel_r <= advance_s ? fwd_s : {NUM_SRC*SW{1'b0}};
    end
  end

  // Saturating count of stalled, non-held cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= 32'd0;
    end else if (!pipe_hold && stall_s && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit: default build plus a
// NUM_SRC=3 / DEPTH=4 / LOAD_STAGE=3 build, expected values hand-computed.
module tb_hazard_forward_unit;

  logic clk;
  logic reset;

  logic        a_id_valid;
  logic [9:0]  a_id_src;
  logic [1:0]  a_id_src_valid;
  logic [4:0]  a_id_dst;
  logic [3:0]  a_id_be;
  logic        a_id_is_load;
  logic        a_pipe_hold;
  logic        a_flush;
  logic        a_stall;
  logic [1:0]  a_id_bypass;
  logic [3:0]  a_ex_fwd_sel;
  logic [31:0] a_stall_count;

  logic        b_id_valid;
  logic [14:0] b_id_src;
  logic [2:0]  b_id_src_valid;
  logic [4:0]  b_id_dst;
  logic [3:0]  b_id_be;
  logic        b_id_is_load;
  logic        b_pipe_hold;
  logic        b_flush;
  logic        b_stall;
  logic [2:0]  b_id_bypass;
  logic [8:0]  b_ex_fwd_sel;
  logic [31:0] b_stall_count;

  int errors;
  int checks;

  hazard_forward_unit dut_a (
    .clk(clk), .reset(reset), .id_valid(a_id_valid), .id_src(a_id_src),
    .id_src_valid(a_id_src_valid), .id_dst(a_id_dst), .id_be(a_id_be),
    .id_is_load(a_id_is_load), .pipe_hold(a_pipe_hold), .flush(a_flush),
    .stall(a_stall), .id_bypass(a_id_bypass), .ex_fwd_sel(a_ex_fwd_sel),
    .stall_count(a_stall_count)
  );

  hazard_forward_unit #(.NUM_SRC(3), .DEPTH(4), .LOAD_STAGE(3)) dut_b (
    .clk(clk), .reset(reset), .id_valid(b_id_valid), .id_src(b_id_src),
    .id_src_valid(b_id_src_valid), .id_dst(b_id_dst), .id_be(b_id_be),
    .id_is_load(b_id_is_load), .pipe_hold(b_pipe_hold), .flush(b_flush),
    .stall(b_stall), .id_bypass(b_id_bypass), .ex_fwd_sel(b_ex_fwd_sel),
    .stall_count(b_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_issue(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] sv,
                         input logic [4:0] dst, input logic [3:0] be, input logic ld);
    a_id_valid     = 1'b1;
    a_id_src       = {s1, s0};
    a_id_src_valid = sv;
    a_id_dst       = dst;
    a_id_be        = be;
    a_id_is_load   = ld;
    #1;
  endtask

  task automatic b_issue(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] sv, input logic [4:0] dst, input logic [3:0] be,
                         input logic ld);
    b_id_valid     = 1'b1;
    b_id_src       = {s2, s1, s0};
    b_id_src_valid = sv;
    b_id_dst       = dst;
    b_id_be        = be;
    b_id_is_load   = ld;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    a_id_valid = 1'b0; a_id_src = 10'd0; a_id_src_valid = 2'b00; a_id_dst = 5'd0;
    a_id_be = 4'h0; a_id_is_load = 1'b0; a_pipe_hold = 1'b0; a_flush = 1'b0;
    b_id_valid = 1'b0; b_id_src = 15'd0; b_id_src_valid = 3'b000; b_id_dst = 5'd0;
    b_id_be = 4'h0; b_id_is_load = 1'b0; b_pipe_hold = 1'b0; b_flush = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    check("rst_sel", 32'(a_ex_fwd_sel), 32'h0);
    check("rst_cnt", a_stall_count, 32'h0);
    check("b_rst_sel", 32'(b_ex_fwd_sel), 32'h0);
    a_issue(5'd3, 5'd3, 2'b11, 5'd4, 4'hF, 1'b0);
    check("rst_stall", 32'(a_stall), 32'h0);
    check("rst_bypass", 32'(a_id_bypass), 32'h0);

    // ALU chain, back-to-back
    a_issue(5'd1, 5'd2, 2'b11, 5'd3, 4'hF, 1'b0); tick;
    a_issue(5'd3, 5'd3, 2'b11, 5'd4, 4'hF, 1'b0);
    check("alu1_stall", 32'(a_stall), 32'h0);
    tick;
    check("alu1_sel", 32'(a_ex_fwd_sel), 32'h5);

    // one instruction between
    a_issue(5'd1, 5'd2, 2'b11, 5'd3, 4'hF, 1'b0); tick;
    a_issue(5'd0, 5'd0, 2'b00, 5'd0, 4'h0, 1'b0); tick;
    a_issue(5'd3, 5'd3, 2'b11, 5'd4, 4'hF, 1'b0);
    check("alu2_stall", 32'(a_stall), 32'h0);
    tick;
    check("alu2_sel", 32'(a_ex_fwd_sel), 32'hA);

    // two between: write-through only
    a_issue(5'd1, 5'd2, 2'b11, 5'd3, 4'hF, 1'b0); tick;
    a_issue(5'd0, 5'd0, 2'b00, 5'd0, 4'h0, 1'b0); tick;
    tick;
    a_issue(5'd3, 5'd3, 2'b11, 5'd4, 4'hF, 1'b0);
    check("alu3_bypass", 32'(a_id_bypass), 32'h3);
    check("alu3_stall", 32'(a_stall), 32'h0);
    tick;
    check("alu3_sel", 32'(a_ex_fwd_sel), 32'h0);

    // load-use
    a_issue(5'd1, 5'd0, 2'b01, 5'd5, 4'hF, 1'b1); tick;
    a_issue(5'd5, 5'd0, 2'b11, 5'd6, 4'hF, 1'b0);
    check("lu_stall", 32'(a_stall), 32'h1);
    check("lu_bypass", 32'(a_id_bypass), 32'h0);
    tick;
    check("lu_bubble", 32'(a_ex_fwd_sel), 32'h0);
    check("lu_cnt1", a_stall_count, 32'd1);
    check("lu_release", 32'(a_stall), 32'h0);
    tick;
    check("lu_fwd", 32'(a_ex_fwd_sel), 32'h2);
    check("lu_cnt2", a_stall_count, 32'd1);

    // priority: younger full write of r7 beats an older partial write of r7
    a_issue(5'd1, 5'd0, 2'b01, 5'd7, 4'h1, 1'b0); tick;
    a_issue(5'd1, 5'd2, 2'b11, 5'd7, 4'hF, 1'b0); tick;
    a_issue(5'd7, 5'd7, 2'b11, 5'd17, 4'hF, 1'b0);
    check("prio_stall", 32'(a_stall), 32'h0);
    tick;
    check("prio_sel", 32'(a_ex_fwd_sel), 32'h5);

    // r0 never matches, even for a load
    a_issue(5'd1, 5'd0, 2'b01, 5'd0, 4'hF, 1'b1); tick;
    a_issue(5'd0, 5'd0, 2'b11, 5'd15, 4'hF, 1'b0);
    check("r0_stall", 32'(a_stall), 32'h0);
    check("r0_bypass", 32'(a_id_bypass), 32'h0);
    tick;
    check("r0_sel", 32'(a_ex_fwd_sel), 32'h0);

    // partial write waits until the writer reaches the tail
    a_issue(5'd1, 5'd0, 2'b01, 5'd8, 4'h1, 1'b0); tick;
    a_issue(5'd8, 5'd1, 2'b01, 5'd16, 4'hF, 1'b0);
    check("pw_stall0", 32'(a_stall), 32'h1);
    tick;
    check("pw_stall1", 32'(a_stall), 32'h1);
    check("pw_bubble", 32'(a_ex_fwd_sel), 32'h0);
    tick;
    check("pw_release", 32'(a_stall), 32'h0);
    check("pw_bypass", 32'(a_id_bypass), 32'h1);
    check("pw_cnt", a_stall_count, 32'd3);
    tick;
    check("pw_sel", 32'(a_ex_fwd_sel), 32'h0);

    // flush during a load-use stall
    a_issue(5'd1, 5'd0, 2'b01, 5'd9, 4'hF, 1'b1); tick;
    a_issue(5'd9, 5'd9, 2'b11, 5'd18, 4'hF, 1'b0);
    check("fl_pre", 32'(a_stall), 32'h1);
    a_flush = 1'b1; #1;
    check("fl_stall", 32'(a_stall), 32'h0);
    tick;
    a_flush = 1'b0; #1;
    check("fl_after", 32'(a_stall), 32'h0);
    check("fl_bypass", 32'(a_id_bypass), 32'h0);
    check("fl_cnt", a_stall_count, 32'd3);
    tick;
    check("fl_sel", 32'(a_ex_fwd_sel), 32'h0);

    // hold for 3 cycles with a pending load-use
    a_issue(5'd1, 5'd0, 2'b01, 5'd10, 4'hF, 1'b0); tick;
    a_issue(5'd10, 5'd10, 2'b11, 5'd11, 4'hF, 1'b0); tick;
    check("h_pre", 32'(a_ex_fwd_sel), 32'h5);
    a_issue(5'd11, 5'd0, 2'b01, 5'd12, 4'hF, 1'b1); tick;
    check("h_lw", 32'(a_ex_fwd_sel), 32'h1);
    a_pipe_hold = 1'b1;
    a_issue(5'd12, 5'd12, 2'b11, 5'd13, 4'hF, 1'b0);
    check("h_stall", 32'(a_stall), 32'h1);
    for (int n = 0; n < 3; n++) begin
      tick;
      check("h_sel", 32'(a_ex_fwd_sel), 32'h1);
      check("h_cnt", a_stall_count, 32'd3);
      check("h_stall_held", 32'(a_stall), 32'h1);
    end
    a_pipe_hold = 1'b0; #1;
    tick;
    check("h_cnt_rel", a_stall_count, 32'd4);
    check("h_bubble", 32'(a_ex_fwd_sel), 32'h0);
    check("h_release", 32'(a_stall), 32'h0);
    tick;
    check("h_fwd", 32'(a_ex_fwd_sel), 32'hA);

    // reset in the middle of a stall
    a_issue(5'd1, 5'd0, 2'b01, 5'd14, 4'hF, 1'b1); tick;
    a_issue(5'd14, 5'd0, 2'b01, 5'd19, 4'hF, 1'b0);
    check("rs_pre", 32'(a_stall), 32'h1);
    reset = 1'b1;
    tick;
    check("rs_cnt", a_stall_count, 32'd0);
    check("rs_sel", 32'(a_ex_fwd_sel), 32'h0);
    reset = 1'b0; #1;
    check("rs_stall", 32'(a_stall), 32'h0);
    a_id_valid = 1'b0;

    // wide build: load-use stalls 2 cycles, then selects stage 3
    b_issue(5'd1, 5'd0, 5'd0, 3'b001, 5'd5, 4'hF, 1'b1); tick;
    b_issue(5'd5, 5'd0, 5'd0, 3'b001, 5'd6, 4'hF, 1'b0);
    check("b_lu0", 32'(b_stall), 32'h1);
    tick;
    check("b_lu1", 32'(b_stall), 32'h1);
    check("b_bubble", 32'(b_ex_fwd_sel), 32'h0);
    tick;
    check("b_lu_rel", 32'(b_stall), 32'h0);
    check("b_cnt", b_stall_count, 32'd2);
    tick;
    check("b_fwd", 32'(b_ex_fwd_sel), 32'h3);

    // wide build: distance-5 dependence on operand 2
    b_issue(5'd1, 5'd0, 5'd0, 3'b001, 5'd20, 4'hF, 1'b0); tick;
    b_issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 4'h0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      tick;
    end
    b_issue(5'd0, 5'd0, 5'd20, 3'b100, 5'd21, 4'hF, 1'b0);
    check("b_d5_bypass", 32'(b_id_bypass), 32'h4);
    check("b_d5_stall", 32'(b_stall), 32'h0);
    tick;
    check("b_d5_sel", 32'(b_ex_fwd_sel), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
